// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the register file's single write port between two writeback
// producers: requester A (load path) and requester B (ALU path). Each side
// owns a small FIFO with a valid/ready handshake. A has fixed priority, and B
// is forced to win once it has lost STARVE_LIMIT arbitrations in a row.
// One write is drained per cycle into registered WriteReg/DstReg/DstData.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   a_valid/a_ready       A handshake; a_reg/a_data = A destination/data
//   b_valid/b_ready       B handshake; b_reg/b_data = B destination/data
//   WriteReg              register file write enable (registered)
//   DstReg / DstData      register file write address / data (registered)
//   pending_mask          bit r set while any queued entry targets register r
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_reg,
    input  logic [15:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_reg,
    input  logic [15:0] b_data,
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    output logic [15:0] pending_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Requester index 0 is A, index 1 is B.
    logic [3:0]    r_fifo_reg  [2][DEPTH];
    logic [15:0]   r_fifo_data [2][DEPTH];
    logic [PW-1:0] r_rd        [2];
    logic [PW-1:0] r_wr        [2];
    logic [CW-1:0] r_cnt       [2];
    logic [SW-1:0] r_starve;
    logic          r_write_reg;
    logic [3:0]    r_dst_reg;
    logic [15:0]   r_dst_data;

    logic [1:0]    w_in_valid;
    logic [3:0]    w_in_reg  [2];
    logic [15:0]   w_in_data [2];
    logic [1:0]    w_ready;
    logic [1:0]    w_enq;
    logic [1:0]    w_deq;
    logic [1:0]    w_ne;
    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_win_any;
    logic [3:0]    w_win_reg;
    logic [15:0]   w_win_data;
    logic [15:0]   w_pending;

    // An entry is live when its distance from the read pointer is below count.
    function automatic logic entry_live(input logic [PW-1:0] idx,
                                        input logic [PW-1:0] rd,
                                        input logic [CW-1:0] cnt);
        logic [PW-1:0] off;
        off = idx - rd;
        return (CW'(off) < cnt);
    endfunction

    assign w_in_valid   = {b_valid, a_valid};
    assign w_in_reg[0]  = a_reg;
    assign w_in_reg[1]  = b_reg;
    assign w_in_data[0] = a_data;
    assign w_in_data[1] = b_data;

    // Ready comes only from the registered count, never from this cycle's dequeue.
    assign w_ready[0] = (r_cnt[0] != CW'(DEPTH));
    assign w_ready[1] = (r_cnt[1] != CW'(DEPTH));
    assign w_enq      = w_in_valid & w_ready;
    assign w_ne[0]    = (r_cnt[0] != {CW{1'b0}});
    assign w_ne[1]    = (r_cnt[1] != {CW{1'b0}});

    // B wins when A is empty or B has exhausted its starvation allowance.
    assign w_grant_b = w_ne[1] && (!w_ne[0] || (r_starve == SW'(STARVE_LIMIT)));
    assign w_grant_a = w_ne[0] && !w_grant_b;
    assign w_deq     = {w_grant_b, w_grant_a};
    assign w_win_any = w_grant_a || w_grant_b;

    // Select the winning FIFO head for the output stage.
    always_comb begin
        w_win_reg  = 4'd0;
        w_win_data = 16'd0;
        if (w_grant_a) begin
            w_win_reg  = r_fifo_reg[0][r_rd[0]];
            w_win_data = r_fifo_data[0][r_rd[0]];
        end else if (w_grant_b) begin
            w_win_reg  = r_fifo_reg[1][r_rd[1]];
            w_win_data = r_fifo_data[1][r_rd[1]];
        end else begin
            w_win_reg  = 4'd0;
            w_win_data = 16'd0;
        end
    end

    // Pending mask: OR of destinations of all live entries; R0 never shows.
    always_comb begin
        w_pending = 16'd0;
        for (int q = 0; q < 2; q++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_pending[r_fifo_reg[q][i]] = w_pending[r_fifo_reg[q][i]] |
                    (entry_live(PW'(i), r_rd[q], r_cnt[q]) &&
                     (r_fifo_reg[q][i] != 4'd0));
            end
        end
        w_pending[0] = 1'b0;
    end

    // FIFO pointers, counts and storage for both requesters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int q = 0; q < 2; q++) begin
                r_rd[q]  <= {PW{1'b0}};
                r_wr[q]  <= {PW{1'b0}};
                r_cnt[q] <= {CW{1'b0}};
                for (int i = 0; i < DEPTH; i++) begin
                    r_fifo_reg[q][i]  <= 4'd0;
                    r_fifo_data[q][i] <= 16'd0;
                end
            end
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (w_enq[q]) begin
                    r_fifo_reg[q][r_wr[q]]  <= w_in_reg[q];
                    r_fifo_data[q][r_wr[q]] <= w_in_data[q];
                    r_wr[q]                 <= r_wr[q] + PW'(1);
                end
                if (w_deq[q]) begin
                    r_rd[q] <= r_rd[q] + PW'(1);
                end
                case ({w_enq[q], w_deq[q]})
                    2'b10:   r_cnt[q] <= r_cnt[q] + CW'(1);
                    2'b01:   r_cnt[q] <= r_cnt[q] - CW'(1);
                    default: r_cnt[q] <= r_cnt[q];
                endcase
            end
        end
    end

    // Starvation counter: counts B's consecutive losses, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= {SW{1'b0}};
        end else if (w_ne[1] && w_grant_a) begin
            if (r_starve != SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + SW'(1);
            end
        end else begin
            r_starve <= {SW{1'b0}};
        end
    end

    // Output stage. Idle and R0 writes drive DstReg=0 because the bypass
    // compares DstReg without looking at WriteReg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write_reg <= 1'b0;
            r_dst_reg   <= 4'd0;
            r_dst_data  <= 16'd0;
        end else if (w_win_any && (w_win_reg != 4'd0)) begin
            r_write_reg <= 1'b1;
            r_dst_reg   <= w_win_reg;
            r_dst_data  <= w_win_data;
        end else begin
            r_write_reg <= 1'b0;
            r_dst_reg   <= 4'd0;
            r_dst_data  <= 16'd0;
        end
    end

    assign a_ready      = w_ready[0];
    assign b_ready      = w_ready[1];
    assign WriteReg     = r_write_reg;
    assign DstReg       = r_dst_reg;
    assign DstData      = r_dst_data;
    assign pending_mask = w_pending;

endmodule
